// File: rtl/line_prefetch_buffer_pkg.sv
// Shared types and constants for the line prefetch buffer: FSM states, line
// geometry defaults and the RGB332 colour expansion.
package line_prefetch_pkg;

    localparam int DEF_H_RES      = 800;
    localparam int DEF_V_RES      = 480;
    localparam int DEF_ADDR_W     = 24;
    localparam int PIX_PER_WORD   = 4;
    localparam int WORDS_PER_LINE = DEF_H_RES / PIX_PER_WORD;

    typedef enum logic {
        IDLE,
        FETCH
    } fsm_state_t;

    // Replicates each colour field's MSBs so full-scale codes map to 0xFF.
    function automatic logic [23:0] rgb332_expand(input logic [7:0] b);
        return {b[7:5], b[7:5], b[7:6],
                b[4:2], b[4:2], b[4:3],
                b[1:0], b[1:0], b[1:0], b[1:0]};
    endfunction

endpackage

// File: rtl/line_prefetch_buffer_if.sv
// Single-outstanding frame-memory read handshake between the prefetch buffer
// (master) and the frame-memory arbiter (slave).
interface line_prefetch_buffer_if
    import line_prefetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (output mem_rd, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_rd, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/line_prefetch_buffer_line_buffer_dp.sv
// Ping-pong line store: two banks of one display line each, one synchronous
// write port (fetch side) and one asynchronous read port (pixel side).
module line_buffer_dp
    import line_prefetch_pkg::*;
#(
    parameter int WORDS  = WORDS_PER_LINE,
    parameter int WORD_W = 8
) (
    input  logic              Clock,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic              rd_bank,
    input  logic [WORD_W-1:0] rd_word,
    output logic [31:0]       rd_data
);

    localparam int DEPTH = 2 * WORDS;
    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // Columns past the line end read word 0; the pixel path blanks them anyway.
    always_comb begin
        wr_idx = IDX_W'(wr_word) + (wr_bank ? IDX_W'(WORDS) : '0);
        rd_idx = '0;
        if (32'(rd_word) < WORDS) begin
            rd_idx = IDX_W'(rd_word) + (rd_bank ? IDX_W'(WORDS) : '0);
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/line_prefetch_buffer.sv
// Prefetches the next display line from frame memory into a ping-pong buffer
// and serves RGB for the current column. LINE_PALETTE_EN adds a 256x24 palette.
module line_prefetch_buffer
    import line_prefetch_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [9:0]             Column_in,
    input  logic [9:0]             Row_in,
    input  logic [ADDR_W-1:0]      FrameBase,
    line_prefetch_buffer_if.master mem_bus,
`ifdef LINE_PALETTE_EN
    input  logic                   pal_we,
    input  logic [7:0]             pal_idx,
    input  logic [23:0]            pal_rgb,
`endif
    output logic [7:0]             Red,
    output logic [7:0]             Green,
    output logic [7:0]             Blue,
    output logic                   Underrun
);

    localparam int LINE_WORDS = H_RES / PIX_PER_WORD;

    fsm_state_t        state, next_state;
    logic              front;
    logic [9:0]        row_q, latched_row, target, next_target;
    logic [ADDR_W-1:0] base, next_base;
    logic [7:0]        word;
    logic              gap;
    logic              line_event, fetch_ack, last_word;
    logic [31:0]       rd_data;
    logic [7:0]        pix_byte;
    logic              visible;
    logic [23:0]       pixel_rgb;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [9:0] t,
                                                    input logic [7:0] w);
        return b + ADDR_W'(t) * ADDR_W'(LINE_WORDS) + ADDR_W'(w);
    endfunction

    // An ack landing on a line event belongs to the aborted fetch and is dropped.
    always_comb begin
        line_event  = (row_q != latched_row);
        fetch_ack   = (state == FETCH) && !gap && mem_bus.mem_ack && !line_event;
        last_word   = (32'(word) == LINE_WORDS - 1);
        next_target = (32'(row_q) + 1 < V_RES) ? row_q + 10'd1 : 10'd0;
        next_base   = (next_target == 10'd0) ? FrameBase : base;
        next_state  = state;
        case (state)
            IDLE:    if (line_event) next_state = FETCH;
            FETCH:   if (!line_event && fetch_ack && last_word) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    assign mem_bus.mem_rd = (state == FETCH) && !gap;

    // Latched row starts at all-ones so the first sampled row is a line event.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            row_q            <= '1;
            latched_row      <= '1;
            front            <= 1'b0;
            target           <= '0;
            base             <= '0;
            word             <= '0;
            gap              <= 1'b0;
            mem_bus.mem_addr <= '0;
            Underrun         <= 1'b0;
        end else begin
            row_q <= Row_in;
            gap   <= 1'b0;
            if (line_event) begin
                front            <= ~front;
                latched_row      <= row_q;
                target           <= next_target;
                base             <= next_base;
                word             <= '0;
                mem_bus.mem_addr <= line_addr(next_base, next_target, 8'd0);
                if (state == FETCH) begin
                    gap      <= 1'b1;
                    Underrun <= 1'b1;
                end
            end else if (fetch_ack) begin
                word             <= word + 8'd1;
                mem_bus.mem_addr <= line_addr(base, target, word + 8'd1);
            end
        end
    end

    line_buffer_dp #(
        .WORDS  (LINE_WORDS),
        .WORD_W (8)
    ) u_line_buffer (
        .Clock   (Clock),
        .wr_en   (fetch_ack),
        .wr_bank (~front),
        .wr_word (word),
        .wr_data (mem_bus.mem_rdata),
        .rd_bank (front),
        .rd_word (Column_in[9:2]),
        .rd_data (rd_data)
    );

    always_comb begin
        pix_byte = 8'(rd_data >> {Column_in[1:0], 3'b000});
        visible  = (32'(Column_in) < H_RES) && (32'(Row_in) < V_RES);
    end

`ifdef LINE_PALETTE_EN
    logic [23:0] palette [256];

    always_ff @(posedge Clock) begin
        if (pal_we) begin
            palette[pal_idx] <= pal_rgb;
        end
    end

    assign pixel_rgb = palette[pix_byte];
`else
    assign pixel_rgb = rgb332_expand(pix_byte);
`endif

    // The palette lookup lands in this same register, keeping latency at one clock.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)        {Red, Green, Blue} <= '0;
        else if (visible) {Red, Green, Blue} <= pixel_rgb;
        else              {Red, Green, Blue} <= '0;
    end

endmodule
